// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap/flush sequencer:
//   - trap_state_e : sequencer FSM states
//   - CAUSE_*      : synchronous exception cause codes raised by the pipeline
//   - MTVEC_*      : mtvec[1:0] mode encodings
// No ports; imported by trap_ctrl and trap_prio_enc.
// ---------------------------------------------------------------------------
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        RET      = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL_INSTR    = 5'd2;
    localparam logic [4:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
    localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_prio_enc
// Parametrised priority encoder.
//   req   in  WIDTH  request vector
//   valid out 1      any request set
//   idx   out IDX_W  winning index: highest set bit when MSB_FIRST=1,
//                    lowest set bit when MSB_FIRST=0 (0 when no request)
// ---------------------------------------------------------------------------
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan in the direction that lets the preferred end overwrite last:
    // ascending keeps the highest set bit, descending keeps the lowest.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Trap/flush sequencer for the in-order pipeline. Arbitrates per-stage
// exceptions, masked interrupts and mret, then walks IDLE -> TRAP/RET ->
// REDIRECT, flushing the pipeline and handing a target PC to fetch.
// IRQ_CAUSE_BASE + N_IRQ must not exceed 32 so irq causes fit in 5 bits.
//   clk, rst (async, active-low)
//   exc_valid_i/cause_i/tval_i/pc_i : per-stage exception requests (packed)
//   irq_i, irq_en_i, gie_i          : level interrupts, mie, mstatus.MIE
//   commit_pc_i                     : epc used for interrupts
//   mret_i, mepc_i                  : mret at commit and its return PC
//   mtvec_i                         : trap vector base/mode
//   redirect_ready_i                : fetch accepted redirect
//   flush_o                         : per-stage flush
//   trap_take_o/is_irq/cause/epc/tval : one-cycle trap commit to CSR file
//   mret_take_o                     : one-cycle mret commit to CSR file
//   redirect_valid_o/pc_o           : redirect handshake to fetch
//   irq_pending_o                   : registered irq_i & irq_en_i
//   busy_o                          : sequencer not idle
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int N_STAGES       = 5,
    parameter int N_IRQ          = 4,
    parameter int XLEN           = 32,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter bit VECTORED_EN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_STAGES-1:0]      exc_valid_i,
    input  logic [5*N_STAGES-1:0]    exc_cause_i,
    input  logic [XLEN*N_STAGES-1:0] exc_tval_i,
    input  logic [XLEN*N_STAGES-1:0] exc_pc_i,
    input  logic [N_IRQ-1:0]         irq_i,
    input  logic [N_IRQ-1:0]         irq_en_i,
    input  logic                     gie_i,
    input  logic [XLEN-1:0]          commit_pc_i,
    input  logic                     mret_i,
    input  logic [XLEN-1:0]          mtvec_i,
    input  logic [XLEN-1:0]          mepc_i,
    input  logic                     redirect_ready_i,
    output logic [N_STAGES-1:0]      flush_o,
    output logic                     trap_take_o,
    output logic                     trap_is_irq_o,
    output logic [4:0]               trap_cause_o,
    output logic [XLEN-1:0]          trap_epc_o,
    output logic [XLEN-1:0]          trap_tval_o,
    output logic                     mret_take_o,
    output logic                     redirect_valid_o,
    output logic [XLEN-1:0]          redirect_pc_o,
    output logic [N_IRQ-1:0]         irq_pending_o,
    output logic                     busy_o
);

    localparam int EXC_IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int IRQ_IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    // The instruction at the oldest stage is the mret itself and must retire.
    localparam logic [N_STAGES-1:0] RET_FLUSH = ~(N_STAGES'(1) << (N_STAGES - 1));

    trap_state_e          state;
    logic [XLEN-1:0]      target_q;

    logic                 exc_any;
    logic [EXC_IDX_W-1:0] exc_idx;
    logic                 irq_any;
    logic [IRQ_IDX_W-1:0] irq_idx;

    logic [4:0]           exc_cause_arr [N_STAGES];
    logic [XLEN-1:0]      exc_tval_arr  [N_STAGES];
    logic [XLEN-1:0]      exc_pc_arr    [N_STAGES];

    logic [4:0]           irq_cause;
    logic [XLEN-1:0]      trap_base;
    logic                 vec_mode;
    logic [XLEN-1:0]      irq_target;

    // Oldest faulting stage wins among exceptions.
    trap_prio_enc #(
        .WIDTH     (N_STAGES),
        .MSB_FIRST (1'b1),
        .IDX_W     (EXC_IDX_W)
    ) u_exc_enc (
        .req   (exc_valid_i),
        .valid (exc_any),
        .idx   (exc_idx)
    );

    // Lowest-numbered pending interrupt wins; arbitration uses the
    // registered pending copy, not the raw lines.
    trap_prio_enc #(
        .WIDTH     (N_IRQ),
        .MSB_FIRST (1'b0),
        .IDX_W     (IRQ_IDX_W)
    ) u_irq_enc (
        .req   (irq_pending_o),
        .valid (irq_any),
        .idx   (irq_idx)
    );

    // Unpack the per-stage buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < N_STAGES; i++) begin
            exc_cause_arr[i] = exc_cause_i[i*5 +: 5];
            exc_tval_arr[i]  = exc_tval_i[i*XLEN +: XLEN];
            exc_pc_arr[i]    = exc_pc_i[i*XLEN +: XLEN];
        end
    end

    // Only interrupts can be vectored; exceptions always go to the base.
    assign irq_cause  = 5'(IRQ_CAUSE_BASE) + 5'(irq_idx);
    assign trap_base  = {mtvec_i[XLEN-1:2], 2'b00};
    assign vec_mode   = VECTORED_EN && (mtvec_i[1:0] == MTVEC_VECTORED);
    assign irq_target = vec_mode ? (trap_base + (XLEN'(irq_cause) << 2)) : trap_base;

    assign busy_o = (state != IDLE);

    // Sequencer FSM with registered outputs. Every output is set on the
    // transition into the state it belongs to, so pulses are exactly one
    // cycle and redirect fields stay stable while fetch stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            target_q         <= '0;
            flush_o          <= '0;
            trap_take_o      <= 1'b0;
            trap_is_irq_o    <= 1'b0;
            trap_cause_o     <= '0;
            trap_epc_o       <= '0;
            trap_tval_o      <= '0;
            mret_take_o      <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            irq_pending_o    <= '0;
        end else begin
            irq_pending_o <= irq_i & irq_en_i;
            case (state)
                IDLE: begin
                    flush_o          <= '0;
                    trap_take_o      <= 1'b0;
                    mret_take_o      <= 1'b0;
                    redirect_valid_o <= 1'b0;
                    if (exc_any) begin
                        state         <= TRAP;
                        flush_o       <= '1;
                        trap_take_o   <= 1'b1;
                        trap_is_irq_o <= 1'b0;
                        trap_cause_o  <= exc_cause_arr[exc_idx];
                        trap_epc_o    <= exc_pc_arr[exc_idx];
                        trap_tval_o   <= exc_tval_arr[exc_idx];
                        target_q      <= trap_base;
                    end else if (gie_i && irq_any) begin
                        state         <= TRAP;
                        flush_o       <= '1;
                        trap_take_o   <= 1'b1;
                        trap_is_irq_o <= 1'b1;
                        trap_cause_o  <= irq_cause;
                        trap_epc_o    <= commit_pc_i;
                        trap_tval_o   <= '0;
                        target_q      <= irq_target;
                    end else if (mret_i) begin
                        state       <= RET;
                        flush_o     <= RET_FLUSH;
                        mret_take_o <= 1'b1;
                        target_q    <= mepc_i;
                    end
                end
                TRAP, RET: begin
                    state            <= REDIRECT;
                    flush_o          <= '1;
                    trap_take_o      <= 1'b0;
                    mret_take_o      <= 1'b0;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= target_q;
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        flush_o          <= '0;
                        redirect_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised trap/flush sequencer for the in-order RISC-V pipeline.
- Arbitrates exception requests from N_STAGES pipeline stages and N_IRQ masked interrupt lines, and handles mret.
- Drives per-stage flushes, one-cycle trap/mret pulses to the CSR file, and a handshaked PC redirect to fetch.
- Replaces the ad-hoc combinational exception/flush logic in the processor top with an explicit FSM.

Parameters:
- N_STAGES, 5: pipeline stages; index 0 = fetch, higher index = older instruction.
- N_IRQ, 4: interrupt request lines.
- XLEN, 32: PC/data width.
- IRQ_CAUSE_BASE, 16: cause code of irq[0]. Legal only if IRQ_CAUSE_BASE+N_IRQ <= 32.
- VECTORED_EN, 1: allows vectored mode when mtvec[1:0]==2'b01.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- exc_valid_i  in  N_STAGES  per-stage exception request.
- exc_cause_i  in  5*N_STAGES  per-stage cause, packed.
- exc_tval_i  in  XLEN*N_STAGES  per-stage trap value.
- exc_pc_i  in  XLEN*N_STAGES  per-stage faulting PC.
- irq_i  in  N_IRQ  level interrupt lines.
- irq_en_i  in  N_IRQ  mie enables.
- gie_i  in  1  mstatus.MIE.
- commit_pc_i  in  XLEN  PC of oldest live instruction; this is the epc for interrupts.
- mret_i  in  1  mret reached commit stage.
- mtvec_i  in  XLEN  trap vector base/mode.
- mepc_i  in  XLEN  return PC.
- redirect_ready_i  in  1  fetch accepted the redirect.
- flush_o  out  N_STAGES  per-stage flush.
- trap_take_o  out  1  trap commit pulse to CSR file.
- trap_is_irq_o  out  1  trap is an interrupt.
- trap_cause_o  out  5  cause code.
- trap_epc_o  out  XLEN  epc.
- trap_tval_o  out  XLEN  mtval.
- mret_take_o  out  1  mret commit pulse.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_pc_o  out  XLEN  redirect target.
- irq_pending_o  out  N_IRQ  registered irq_i & irq_en_i.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs and latches 0; irq_pending_o=0.
- irq_pending_o: registered every cycle as irq_i & irq_en_i. Irq win is decided from this registered copy.
- FSM states: IDLE, TRAP, RET, REDIRECT.
- IDLE, priority order:
  - (1) Any exc_valid_i: winner = highest set index (oldest). Latch its cause/tval/pc as epc; is_irq=0. Next state TRAP.
  - (2) Else gie_i & |irq_pending_o: winner = lowest set index k; cause=IRQ_CAUSE_BASE+k; epc=commit_pc_i; tval=0; is_irq=1. Next state TRAP.
  - (3) Else mret_i: latch mepc_i. Next state RET.
  - Outputs in IDLE: flush_o=0, no pulses, redirect_valid_o=0.
- Target calculation (in IDLE): base={mtvec_i[XLEN-1:2],2'b00}. Target = base + (cause<<2) only when is_irq & VECTORED_EN & mtvec_i[1:0]==2'b01; otherwise target = base. Addition wraps modulo 2^XLEN.
- TRAP (exactly 1 cycle): flush_o all ones; trap_take_o=1 with latched fields. Next state REDIRECT.
- RET (exactly 1 cycle): flush_o = all ones except bit N_STAGES-1, so the mret itself retires; mret_take_o=1. Next state REDIRECT with target=latched mepc.
- REDIRECT:
  - flush_o all ones; redirect_valid_o=1; redirect_pc_o=target, held stable.
  - On redirect_ready_i, go to IDLE next cycle.
  - Valid never drops before ready; waiting is unbounded.
- Inputs outside IDLE: exc_valid_i, mret_i and irqs are ignored. A still-pending level irq is re-evaluated on return to IDLE.
- Latency: request in IDLE at cycle n → trap_take_o/flush at n+1 → redirect_valid_o from n+2. Minimum trap-to-IDLE is 3 cycles.
- Simultaneous events: exception > interrupt > mret. An mret whose own stage raises an exception traps instead.
- Reset asserted mid-sequence: immediate return to IDLE, pulses cleared, no redirect issued.

Decomposition:
- Shared package trap_pkg holds:
  - state enum (IDLE/TRAP/RET/REDIRECT);
  - exception cause constants (0 misaligned fetch, 2 illegal instr, 4/6 misaligned load/store, 11 ecall);
  - MTVEC_DIRECT=2'b00 and MTVEC_VECTORED=2'b01.
- One sub-module: trap_prio_enc, a parametrised priority encoder (WIDTH, MSB_FIRST) outputting valid and index. Instantiated twice: exceptions with MSB_FIRST=1, irqs with MSB_FIRST=0.

Test Plan:
- Stage 3 raises cause 2, tval 0x0000_0013, pc 0x100; mtvec 0x200 → next cycle trap_take_o=1, cause 2, epc 0x100, flush_o=5'b11111; then redirect_pc_o=0x200.
- Stages 1 and 4 raise together (causes 0 and 6) → stage 4 wins: cause 6, epc=exc_pc_i[4].
- irq_i[2]=1, irq_en_i[2]=1, gie_i=1, mtvec 0x1001, commit_pc 0x80 → is_irq=1, cause 18, epc 0x80, redirect_pc_o=0x1048. Same case with gie_i=0 → no trap, irq_pending_o=4'b0100.
- mret_i with mepc 0x3C → mret_take_o=1, flush_o=5'b01111, then redirect_pc_o=0x3C. mret plus same-cycle exception → trap only, mret_take_o never asserts.
- redirect_ready_i held low 10 cycles → redirect_valid_o and redirect_pc_o stable, busy_o=1, new exc_valid_i ignored. Ready high → IDLE next cycle.
- rst low while in REDIRECT → all outputs 0 asynchronously. After release, IDLE with no redirect issued.
